// File: rtl/mix_round_seq.sv
// Lane-serial sequencer for the 8-lane mixing datapath: one lane update per clock.
// Define MIX_FINAL_EN to include the FIN (multiply/add) phase at the end of each run.
module mix_round_seq #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic         ld_en,
    input  logic [2:0]   ld_idx,
    input  logic [W-1:0] ld_data,
    input  logic [2:0]   rd_idx,
    output logic [W-1:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic [2:0]   phase,
    output logic [2:0]   lane
);

    localparam int unsigned NL = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_CHAIN = 3'd2,
        S_MIX   = 3'd3,
        S_XS    = 3'd4,
        S_SH    = 3'd5,
        S_FIN   = 3'd6
    } state_t;

`ifdef MIX_FINAL_EN
    localparam state_t S_END = S_FIN;
`else
    localparam state_t S_END = S_IDLE;
`endif

    state_t         state_q, state_d;
    logic [2:0]     lane_q, lane_d;
    logic [3:0]     rnd_q, rnd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   rd_data_q;
    logic [W-1:0]   o_q [NL];
    logic           last;
    logic [2:0]     idx_m1, idx_p1, idx_p2, idx_p3, idx_p4, idx_p5;
    logic [W-1:0]   cur, wr_val;

    assign last = (lane_q == 3'd7);

    // State register plus the registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lane_q  <= 3'd0;
            rnd_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: each phase advances only when its lane-7 operation completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last) state_d = S_CHAIN;
            S_CHAIN: if (last) state_d = (rnd_q != 4'd0) ? S_MIX : S_END;
            S_MIX:   if (last) state_d = S_XS;
            S_XS:    if (last) state_d = S_SH;
            S_SH:    if (last) state_d = (rnd_q > 4'd1) ? S_MIX : S_END;
            S_FIN:   if (last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and counters; the lane counter wraps 7->0 across phase changes
    always_comb begin
        lane_d = 3'd0;
        rnd_d  = rnd_q;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
        if (state_q == S_IDLE) begin
            if (start) rnd_d = rounds;
        end else begin
            lane_d = lane_q + 3'd1;
            if (state_q == S_SH && last) rnd_d = rnd_q - 4'd1;
        end
    end

    always_comb begin
        idx_m1 = lane_q - 3'd1;
        idx_p1 = lane_q + 3'd1;
        idx_p2 = lane_q + 3'd2;
        idx_p3 = lane_q + 3'd3;
        idx_p4 = lane_q + 3'd4;
        idx_p5 = lane_q + 3'd5;
        cur    = o_q[lane_q];
    end

`ifdef MIX_FINAL_EN
    logic [4:0] k_sel, c_sel;

    always_comb begin
        k_sel = 5'd0;
        c_sel = 5'd0;
        case (lane_q)
            3'd0: begin k_sel = 5'd2;  c_sel = 5'd3;  end
            3'd1: begin k_sel = 5'd3;  c_sel = 5'd5;  end
            3'd2: begin k_sel = 5'd5;  c_sel = 5'd7;  end
            3'd3: begin k_sel = 5'd7;  c_sel = 5'd11; end
            3'd4: begin k_sel = 5'd11; c_sel = 5'd13; end
            3'd5: begin k_sel = 5'd13; c_sel = 5'd17; end
            3'd6: begin k_sel = 5'd17; c_sel = 5'd19; end
            default: begin k_sel = 5'd19; c_sel = 5'd23; end
        endcase
    end
`endif

    // Lane operation for the current phase; reads see earlier writes of this phase
    always_comb begin
        wr_val = cur;
        case (state_q)
            S_ADD:   wr_val = cur + W'(lane_q);
            S_CHAIN: wr_val = cur + o_q[idx_m1];
            S_MIX:   wr_val = cur + o_q[idx_p1] - o_q[idx_p5];
            S_XS:    wr_val = cur ^ (o_q[idx_p3] << 16);
            S_SH:    wr_val = cur - (o_q[idx_p2] >> 17) + (o_q[idx_p4] >> 12);
`ifdef MIX_FINAL_EN
            S_FIN:   wr_val = cur * W'(k_sel) + W'(c_sel);
`endif
            default: wr_val = cur;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) o_q[i] <= W'(i);
        end else if (state_q == S_IDLE) begin
            if (ld_en) o_q[ld_idx] <= ld_data;
        end else begin
            o_q[lane_q] <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= o_q[rd_idx];
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign phase   = state_q;
    assign lane    = lane_q;

endmodule

// File: tb/tb_mix_round_seq.sv
// Scoreboard bench for mix_round_seq; expectations follow MIX_FINAL_EN when defined.
module tb_mix_round_seq;

`ifdef MIX_FINAL_EN
    localparam int FIN_LEN = 8;
    localparam bit HAS_FIN = 1'b1;
`else
    localparam int FIN_LEN = 0;
    localparam bit HAS_FIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  rounds = 4'd0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_idx = 3'd0;
    logic [31:0] ld_data = 32'd0;
    logic [2:0]  rd_idx = 3'd0;
    logic [31:0] rd_data;
    logic        busy, done;
    logic [2:0]  phase, lane;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    logic [31:0] rd_q [$];
    int          done_q [$];
    logic [31:0] ev [8];
    logic [31:0] m  [8];
    int kk [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int cc [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

    mix_round_seq #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rounds(rounds),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done),
        .phase(phase), .lane(lane)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops expected read data and expected done edges as the DUT presents them
    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got %0h with no expectation", rd_data);
            end else begin
                chk("rd_data", rd_data, rd_q.pop_front());
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                chk("done_edge", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
    end

    function automatic int run_len(input int r);
        return 16 + 24 * r + FIN_LEN;
    endfunction

    task automatic model(input int r);
        for (int i = 0; i < 8; i++) m[i] = m[i] + 32'(i);
        for (int i = 0; i < 8; i++) m[i] = m[i] + m[(i + 7) % 8];
        for (int rr = 0; rr < r; rr++) begin
            for (int i = 0; i < 8; i++) m[i] = m[i] + m[(i + 1) % 8] - m[(i + 5) % 8];
            for (int i = 0; i < 8; i++) m[i] = m[i] ^ (m[(i + 3) % 8] << 16);
            for (int i = 0; i < 8; i++) m[i] = m[i] - (m[(i + 2) % 8] >> 17) + (m[(i + 4) % 8] >> 12);
        end
        if (HAS_FIN)
            for (int i = 0; i < 8; i++) m[i] = m[i] * 32'(kk[i]) + 32'(cc[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 32'(i);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_idx = 3'(i);
            rd_req = 1'b1;
            rd_q.push_back(ev[i]);
        end
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run(input int r, input bit ld, input logic [2:0] idx, input logic [31:0] d);
        @(negedge clk);
        start   = 1'b1;
        rounds  = 4'(r);
        ld_en   = ld;
        ld_idx  = idx;
        ld_data = d;
        done_q.push_back(cyc + 1 + run_len(r));
    endtask

    task automatic wait_run(input int exp_n, input bit inject);
        int cnt = 0;
        @(negedge clk);
        start = 1'b0;
        ld_en = 1'b0;
        while (busy && cnt < 2000) begin
            cnt++;
            if (inject && cnt == 10) begin
                start = 1'b1; rounds = 4'd9;
                ld_en = 1'b1; ld_idx = 3'd0; ld_data = 32'hDEAD;
            end
            @(negedge clk);
            start = 1'b0;
            ld_en = 1'b0;
        end
        chk("busy_cycles", 32'(cnt), 32'(exp_n));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_phase", {29'd0, phase}, 32'd0);
        chk("rst_lane", {29'd0, lane}, 32'd0);
        model_reset(); ev = m;
        read_all();

        // R = 0 from reset values
        start_run(0, 1'b0, 3'd0, 32'd0);
        wait_run(run_len(0), 1'b0);
        if (HAS_FIN) ev = '{31, 53, 107, 193, 387, 589, 971, 1353};
        else         ev = '{14, 16, 20, 26, 34, 44, 56, 70};
        read_all();

        // Wrap-around of lane 7
        pulse_reset();
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 3'd7; ld_data = 32'hFFFF_FFFF;
        @(negedge clk);
        ld_en = 1'b0;
        start_run(0, 1'b0, 3'd0, 32'd0);
        wait_run(run_len(0), 1'b0);
        if (HAS_FIN) ev = '{15, 29, 67, 137, 299, 485, 835, 1049};
        else         ev = '{6, 8, 12, 18, 26, 36, 48, 54};
        read_all();

        // R = 2 with start/ld_en pulsed mid-run
        pulse_reset();
        start_run(2, 1'b0, 3'd0, 32'd0);
        wait_run(run_len(2), 1'b1);
        model_reset(); model(2); ev = m;
        read_all();

        // Reset mid-run, then a normal run with load+start in the same cycle
        pulse_reset();
        start_run(3, 1'b0, 3'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        pulse_reset();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_phase", {29'd0, phase}, 32'd0);
        chk("abort_lane", {29'd0, lane}, 32'd0);
        model_reset(); ev = m;
        read_all();
        start_run(1, 1'b1, 3'd3, 32'd100);
        wait_run(run_len(1), 1'b0);
        model_reset(); m[3] = 32'd100; model(1); ev = m;
        read_all();

        repeat (3) @(negedge clk);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
